// File: rtl/swarm_pkg.sv
// Shared swarm types used by the task fetch path.
//   task_type_t     : task type selector, TASK_TYPE_ALL requests any type
//   cq_slice_slot_t : commit-queue slot of a granted task
//   core_id_t       : core index carried on finish events
//   task_t          : task descriptor returned by the serializer
package swarm;

  typedef logic [3:0] task_type_t;
  typedef logic [3:0] cq_slice_slot_t;
  typedef logic [3:0] core_id_t;

  typedef struct packed {
    logic [7:0]  hint;
    task_type_t  ttype;
    logic [31:0] args;
  } task_t;

  localparam task_type_t TASK_TYPE_ALL = 4'hF;

endpackage

// File: rtl/task_fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
//   clk, rstn : clock / sync active-low reset
//   inc       : count by one this cycle (ignored once at all-ones)
//   value     : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {WIDTH{1'b1}})) value_d = value_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/task_fetch_unit.sv
// Per-core task fetch unit: requests a task from the serializer, offers the
// granted task to the core, waits for the core to finish it and reports the
// finish event to the shared finish arbiter before asking for another task.
//   clk, rstn                         : clock / sync active-low reset
//   enable, req_ttype                 : core may fetch / type to request
//   m_arvalid, m_araddr               : request to serializer (no ready)
//   m_rvalid, m_rdata, m_cq_slot      : grant pulse with task and CQ slot
//   task_valid/out/cq_slot, task_ready: task offer to the core
//   task_done                         : core finished its running task
//   finish_valid/core, finish_ready   : finish event handshake
//   idle, tasks_completed, wait_cycles: status and statistics
module task_fetch_unit
  import swarm::*;
#(
  parameter int CORE_ID = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           enable,
  input  task_type_t     req_ttype,
  output logic           m_arvalid,
  output task_type_t     m_araddr,
  input  logic           m_rvalid,
  input  task_t          m_rdata,
  input  cq_slice_slot_t m_cq_slot,
  output logic           task_valid,
  output task_t          task_out,
  output cq_slice_slot_t task_cq_slot,
  input  logic           task_ready,
  input  logic           task_done,
  output logic           finish_valid,
  output core_id_t       finish_core,
  input  logic           finish_ready,
  output logic           idle,
  output logic [31:0]    tasks_completed,
  output logic [31:0]    wait_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DRAIN, S_HAND, S_RUN, S_FIN
  } state_e;

  state_e         state_q, state_d;
  task_type_t     araddr_q;
  task_t          task_q;
  cq_slice_slot_t slot_q;
  logic           err_unexpected_grant;

  // A grant is only legal while a request is outstanding; DRAIN catches a
  // grant that was already in flight when enable dropped.
  logic grant_ok, grant_take, grant_bad;
  assign grant_ok   = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign grant_take = m_rvalid && grant_ok;
  assign grant_bad  = m_rvalid && !grant_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_REQ;
      S_REQ:   if (m_rvalid) state_d = S_HAND;
               else if (!enable) state_d = S_DRAIN;
      S_DRAIN: state_d = m_rvalid ? S_HAND : S_IDLE;
      S_HAND:  if (task_ready) state_d = S_RUN;
      // task_done is only looked at here, so a pulse in HAND is dropped
      S_RUN:   if (task_done) state_d = S_FIN;
      S_FIN:   if (finish_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q              <= S_IDLE;
      err_unexpected_grant <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_bad) err_unexpected_grant <= 1'b1;
    end
  end

  // Data registers carry no meaningful reset value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      araddr_q <= 'x;
      task_q   <= 'x;
      slot_q   <= 'x;
    end else begin
      // request type is frozen for the whole REQ stay
      if (state_q == S_IDLE && enable) araddr_q <= req_ttype;
      if (grant_take) begin
        task_q <= m_rdata;
        slot_q <= m_cq_slot;
      end
    end
  end

  assign m_arvalid    = (state_q == S_REQ);
  assign m_araddr     = araddr_q;
  assign task_valid   = (state_q == S_HAND);
  assign task_out     = task_q;
  assign task_cq_slot = slot_q;
  assign finish_valid = (state_q == S_FIN);
  assign finish_core  = core_id_t'(CORE_ID);
  assign idle         = (state_q == S_IDLE);

  sat_counter #(.WIDTH(32)) u_done_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (finish_valid && finish_ready),
    .value (tasks_completed)
  );

  sat_counter #(.WIDTH(32)) u_wait_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (state_q == S_REQ),
    .value (wait_cycles)
  );

endmodule

// File: tb/tb_task_fetch_unit.sv
module tb_task_fetch_unit;
  import swarm::*;

  localparam int CID = 3;

  logic           clk = 1'b0;
  logic           rstn, enable, m_rvalid, task_ready, task_done, finish_ready;
  task_type_t     req_ttype, m_araddr;
  task_t          m_rdata, task_out;
  cq_slice_slot_t m_cq_slot, task_cq_slot;
  logic           m_arvalid, task_valid, finish_valid, idle;
  core_id_t       finish_core;
  logic [31:0]    tasks_completed, wait_cycles;

  int total = 0;
  int bad   = 0;

  task_fetch_unit #(.CORE_ID(CID)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req_ttype(req_ttype),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_cq_slot(m_cq_slot), .task_valid(task_valid),
    .task_out(task_out), .task_cq_slot(task_cq_slot), .task_ready(task_ready),
    .task_done(task_done), .finish_valid(finish_valid),
    .finish_core(finish_core), .finish_ready(finish_ready), .idle(idle),
    .tasks_completed(tasks_completed), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  // advance one cycle; outputs are looked at 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic task_t rand_task();
    task_t t;
    t.hint  = 8'($urandom);
    t.ttype = 4'($urandom);
    t.args  = $urandom;
    return t;
  endfunction

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; req_ttype = '0; m_rvalid = 1'b0;
    m_rdata = '0; m_cq_slot = '0; task_ready = 1'b0; task_done = 1'b0;
    finish_ready = 1'b0;
    step(); step();
    rstn = 1'b1;
  endtask

  // IDLE -> REQ -> grant -> HAND, returns the granted task/slot
  task automatic go_hand(output task_t t, output cq_slice_slot_t s);
    enable = 1'b1;
    step();
    t = rand_task(); s = 4'($urandom);
    m_rvalid = 1'b1; m_rdata = t; m_cq_slot = s;
    step();
    m_rvalid = 1'b0;
  endtask

  task automatic go_run();
    task_t t; cq_slice_slot_t s;
    go_hand(t, s);
    task_ready = 1'b1;
    step();
    task_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got %b want 1", idle); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got %b want 0", m_arvalid); end
    total++; if (task_valid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got %b want 0", task_valid); end
    total++; if (finish_valid !== 1'b0) begin bad++; $display("FAIL rst_fvalid got %b want 0", finish_valid); end
    total++; if (tasks_completed !== 32'd0) begin bad++; $display("FAIL rst_done got %0d want 0", tasks_completed); end
    total++; if (wait_cycles !== 32'd0) begin bad++; $display("FAIL rst_wait got %0d want 0", wait_cycles); end
    total++; if (dut.err_unexpected_grant !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", dut.err_unexpected_grant); end
  endtask

  // enable=1, type 2, grant on cycle 3 with hint 0x55 / slot 7
  task automatic test_basic();
    task_t t;
    do_reset();
    enable = 1'b1; req_ttype = 4'd2;
    t = rand_task(); t.hint = 8'h55;
    for (int c = 1; c <= 3; c++) begin
      step();
      req_ttype = 4'(c + 5);  // must not disturb the latched request type
      total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL basic_arvalid c%0d got %b want 1", c, m_arvalid); end
      total++; if (m_araddr !== 4'd2) begin bad++; $display("FAIL basic_araddr c%0d got %0d want 2", c, m_araddr); end
    end
    m_rvalid = 1'b1; m_rdata = t; m_cq_slot = 4'd7;
    step();
    m_rvalid = 1'b0; m_rdata = rand_task();
    total++; if (task_valid !== 1'b1) begin bad++; $display("FAIL basic_tvalid got %b want 1", task_valid); end
    total++; if (task_out !== t) begin bad++; $display("FAIL basic_task got %h want %h", task_out, t); end
    total++; if (task_cq_slot !== 4'd7) begin bad++; $display("FAIL basic_slot got %0d want 7", task_cq_slot); end
    total++; if (wait_cycles !== 32'd3) begin bad++; $display("FAIL basic_wait got %0d want 3", wait_cycles); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL basic_arvalid_hand got %b want 0", m_arvalid); end
  endtask

  task automatic test_drain();
    task_t t;
    do_reset();
    enable = 1'b1; req_ttype = TASK_TYPE_ALL;
    step();
    total++; if (m_araddr !== TASK_TYPE_ALL) begin bad++; $display("FAIL drain_araddr got %h want %h", m_araddr, TASK_TYPE_ALL); end
    enable = 1'b0;
    step();
    total++; if (m_arvalid !== 1'b0 || idle !== 1'b0 || task_valid !== 1'b0) begin bad++; $display("FAIL drain_state got arv=%b idle=%b tv=%b want 0 0 0", m_arvalid, idle, task_valid); end
    t = rand_task();
    m_rvalid = 1'b1; m_rdata = t; m_cq_slot = 4'd9;
    step();
    m_rvalid = 1'b0;
    total++; if (task_valid !== 1'b1 || task_out !== t || task_cq_slot !== 4'd9) begin bad++; $display("FAIL drain_offer got v=%b %h/%0d want 1 %h/9", task_valid, task_out, task_cq_slot, t); end
    total++; if (dut.err_unexpected_grant !== 1'b0) begin bad++; $display("FAIL drain_err got %b want 0", dut.err_unexpected_grant); end
    total++; if (wait_cycles !== 32'd1) begin bad++; $display("FAIL drain_wait got %0d want 1", wait_cycles); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL drain_noreq got %b want 0", m_arvalid); end
    end
    // drain with no grant falls back to idle
    do_reset();
    enable = 1'b1; step();
    enable = 1'b0; step(); step();
    total++; if (idle !== 1'b1 || m_arvalid !== 1'b0) begin bad++; $display("FAIL drain_idle got idle=%b arv=%b want 1 0", idle, m_arvalid); end
  endtask

  task automatic test_stall();
    task_t t; cq_slice_slot_t s;
    do_reset();
    go_hand(t, s);
    for (int i = 0; i < 5; i++) begin
      m_rdata = rand_task(); m_cq_slot = 4'($urandom);
      step();
      total++; if (task_valid !== 1'b1 || task_out !== t || task_cq_slot !== s) begin bad++; $display("FAIL stall_hold i%0d got v=%b %h/%0d want 1 %h/%0d", i, task_valid, task_out, task_cq_slot, t, s); end
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL stall_arvalid got %b want 0", m_arvalid); end
    end
    // done together with the handshake is dropped
    task_ready = 1'b1; task_done = 1'b1;
    step();
    task_ready = 1'b0; task_done = 1'b0;
    total++; if (task_valid !== 1'b0) begin bad++; $display("FAIL stall_accept got %b want 0", task_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (finish_valid !== 1'b0) begin bad++; $display("FAIL stall_donedrop got %b want 0", finish_valid); end
    end
    task_done = 1'b1; step(); task_done = 1'b0;
    total++; if (finish_valid !== 1'b1) begin bad++; $display("FAIL stall_fin got %b want 1", finish_valid); end
  endtask

  task automatic test_finish_bp();
    do_reset();
    go_run();
    enable = 1'b1;
    step();
    task_done = 1'b1; step(); task_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (finish_valid !== 1'b1 || finish_core !== core_id_t'(CID)) begin bad++; $display("FAIL fin_hold i%0d got v=%b core=%0d want 1 %0d", i, finish_valid, finish_core, CID); end
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL fin_arvalid got %b want 0", m_arvalid); end
      step();
    end
    total++; if (finish_valid !== 1'b1 || tasks_completed !== 32'd0) begin bad++; $display("FAIL fin_pre got v=%b n=%0d want 1 0", finish_valid, tasks_completed); end
    finish_ready = 1'b1; step(); finish_ready = 1'b0;
    total++; if (tasks_completed !== 32'd1) begin bad++; $display("FAIL fin_count got %0d want 1", tasks_completed); end
    total++; if (finish_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL fin_idle got v=%b idle=%b want 0 1", finish_valid, idle); end
    step();
    total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL fin_nextreq got %b want 1", m_arvalid); end
  endtask

  task automatic test_unexpected_grant();
    do_reset();
    go_run();
    m_rvalid = 1'b1; m_rdata = rand_task(); step(); m_rvalid = 1'b0;
    total++; if (dut.err_unexpected_grant !== 1'b1) begin bad++; $display("FAIL ug_err got %b want 1", dut.err_unexpected_grant); end
    total++; if (task_valid | finish_valid | idle | m_arvalid) begin bad++; $display("FAIL ug_state got tv=%b fv=%b idle=%b arv=%b want 0", task_valid, finish_valid, idle, m_arvalid); end
    task_done = 1'b1; step(); task_done = 1'b0;
    total++; if (finish_valid !== 1'b1) begin bad++; $display("FAIL ug_stillrun got %b want 1", finish_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    go_run();
    rstn = 1'b0; enable = 1'b0; step(); rstn = 1'b1;
    total++; if (idle !== 1'b1 || m_arvalid | task_valid | finish_valid) begin bad++; $display("FAIL rmid_state got idle=%b arv=%b tv=%b fv=%b", idle, m_arvalid, task_valid, finish_valid); end
    total++; if (wait_cycles !== 32'd0 || tasks_completed !== 32'd0) begin bad++; $display("FAIL rmid_cnt got w=%0d n=%0d want 0 0", wait_cycles, tasks_completed); end
    for (int i = 0; i < 3; i++) begin
      task_done = (i == 0); step(); task_done = 1'b0;
      total++; if (finish_valid !== 1'b0) begin bad++; $display("FAIL rmid_nofin got %b want 0", finish_valid); end
    end
  endtask

  // Transaction-level model: every task costs (grant latency + 1) REQ
  // cycles and adds one completion; offered data equals the granted data.
  task automatic test_random();
    int exp_wait = 0, exp_done = 0;
    task_t t; cq_slice_slot_t s; task_type_t tt;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      int lat = $urandom_range(0, 3);
      bit drain = ($urandom_range(0, 3) == 0);
      tt = 4'($urandom); req_ttype = tt; enable = 1'b1;
      step();
      for (int k = 0; k < lat; k++) begin
        req_ttype = 4'($urandom);
        step();
      end
      total++; if (m_arvalid !== 1'b1 || m_araddr !== tt) begin bad++; $display("FAIL rnd_req n%0d got arv=%b a=%0d want 1 %0d", n, m_arvalid, m_araddr, tt); end
      exp_wait += lat + 1;
      if (drain) begin enable = 1'b0; step(); end
      t = rand_task(); s = 4'($urandom);
      m_rvalid = 1'b1; m_rdata = t; m_cq_slot = s;
      step();
      m_rvalid = 1'b0; enable = 1'($urandom);
      total++; if (task_valid !== 1'b1 || task_out !== t || task_cq_slot !== s) begin bad++; $display("FAIL rnd_offer n%0d got v=%b %h/%0d want 1 %h/%0d", n, task_valid, task_out, task_cq_slot, t, s); end
      repeat ($urandom_range(0, 3)) step();
      task_ready = 1'b1; step(); task_ready = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      task_done = 1'b1; step(); task_done = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      total++; if (finish_valid !== 1'b1 || m_arvalid !== 1'b0) begin bad++; $display("FAIL rnd_fin n%0d got fv=%b arv=%b want 1 0", n, finish_valid, m_arvalid); end
      finish_ready = 1'b1; step(); finish_ready = 1'b0;
      exp_done++;
      total++; if (tasks_completed !== 32'(exp_done) || wait_cycles !== 32'(exp_wait)) begin bad++; $display("FAIL rnd_cnt n%0d got n=%0d w=%0d want %0d %0d", n, tasks_completed, wait_cycles, exp_done, exp_wait); end
    end
    total++; if (dut.err_unexpected_grant !== 1'b0) begin bad++; $display("FAIL rnd_err got %b want 0", dut.err_unexpected_grant); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_stall();
    test_finish_bp();
    test_unexpected_grant();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
